mdr_sequencer: RTL and testbench

MDR_SEQUENCER -- requirements
Module: mdr_sequencer

---
 rtl/mdr_sequencer.sv | 130 +++++++++++++
 tb/tb_mdr_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdr_sequencer.sv
// Operation sequencer for external multiply/divide/root units: captures a request,
// launches the selected unit, waits for its completion or a timeout, and reports the result.
module mdr_sequencer #(
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic [1:0]    i_op,
  input  logic [DW-1:0] i_dataX,
  input  logic [DW-1:0] i_dataY,
  input  logic          i_mult_done,
  input  logic          i_div_done,
  input  logic          i_root_done,
  input  logic [DW-1:0] i_mult_product,
  input  logic [DW-1:0] i_div_quot,
  input  logic [DW-1:0] i_div_rem,
  input  logic [DW-1:0] i_root_quot,
  input  logic [DW-1:0] i_root_rem,
  output logic          o_mult_enable,
  output logic          o_div_enable,
  output logic          o_root_enable,
  output logic [DW-1:0] o_opX,
  output logic [DW-1:0] o_opY,
  output logic          o_busy,
  output logic          o_done,
  output logic [DW-1:0] o_result,
  output logic [DW-1:0] o_remainder,
  output logic          o_error
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;
  typedef enum logic [1:0] {OP_MUL, OP_DIV, OP_ROOT, OP_ILL} op_t;

  localparam logic [7:0] TO = 8'(TIMEOUT);

  state_t     state;
  op_t        op_q;
  logic [7:0] cnt;
  logic       sel_done;

  always_comb begin
    sel_done = 1'b0;
    case (op_q)
      OP_MUL:  sel_done = i_mult_done;
      OP_DIV:  sel_done = i_div_done;
      OP_ROOT: sel_done = i_root_done;
      default: sel_done = 1'b0;
    endcase
  end

  // Outputs are registered on the transition into the state that owns them,
  // so enables are high exactly during LAUNCH and o_done exactly during DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      op_q          <= OP_MUL;
      cnt           <= '0;
      o_mult_enable <= 1'b0;
      o_div_enable  <= 1'b0;
      o_root_enable <= 1'b0;
      o_opX         <= '0;
      o_opY         <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_result      <= '0;
      o_remainder   <= '0;
      o_error       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            o_opX   <= i_dataX;
            o_opY   <= i_dataY;
            op_q    <= op_t'(i_op);
            o_error <= 1'b0;
            o_busy  <= 1'b1;
            if (i_op == 2'b11 || (i_op == 2'b01 && i_dataY == '0)) begin
              state       <= DONE;
              o_done      <= 1'b1;
              o_error     <= 1'b1;
              o_result    <= '0;
              o_remainder <= '0;
            end else begin
              state         <= LAUNCH;
              o_mult_enable <= (i_op == 2'b00);
              o_div_enable  <= (i_op == 2'b01);
              o_root_enable <= (i_op == 2'b10);
            end
          end
        end
        LAUNCH: begin
          o_mult_enable <= 1'b0;
          o_div_enable  <= 1'b0;
          o_root_enable <= 1'b0;
          cnt           <= '0;
          state         <= WAIT;
        end
        WAIT: begin
          if (sel_done) begin
            state    <= DONE;
            o_done   <= 1'b1;
            o_result <= (op_q == OP_MUL) ? i_mult_product :
                        (op_q == OP_DIV) ? i_div_quot : i_root_quot;
            o_remainder <= (op_q == OP_MUL) ? '0 :
                           (op_q == OP_DIV) ? i_div_rem : i_root_rem;
          end else begin
            // Abort on the WAIT cycle in which the count reaches TIMEOUT.
            cnt <= cnt + 8'd1;
            if (cnt + 8'd1 == TO) begin
              state       <= DONE;
              o_done      <= 1'b1;
              o_error     <= 1'b1;
              o_result    <= '0;
              o_remainder <= '0;
            end
          end
        end
        DONE: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdr_sequencer.sv
// Scoreboard bench for mdr_sequencer: expected results are queued at each start and
// compared against the DUT when o_done pulses.
module tb_mdr_sequencer;
  localparam int DW = 16;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_start = 1'b0;
  logic [1:0]    i_op = '0;
  logic [DW-1:0] i_dataX = '0, i_dataY = '0;
  logic          i_mult_done = 1'b0, i_div_done = 1'b0, i_root_done = 1'b0;
  logic [DW-1:0] i_mult_product = '0, i_div_quot = '0, i_div_rem = '0;
  logic [DW-1:0] i_root_quot = '0, i_root_rem = '0;
  logic          o_mult_enable, o_div_enable, o_root_enable;
  logic [DW-1:0] o_opX, o_opY, o_result, o_remainder;
  logic          o_busy, o_done, o_error;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [DW-1:0] result;
    logic [DW-1:0] rem;
    logic          err;
    int            lat;
  } exp_t;
  exp_t sb[$];

  mdr_sequencer #(.DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_op(i_op),
    .i_dataX(i_dataX), .i_dataY(i_dataY),
    .i_mult_done(i_mult_done), .i_div_done(i_div_done), .i_root_done(i_root_done),
    .i_mult_product(i_mult_product), .i_div_quot(i_div_quot), .i_div_rem(i_div_rem),
    .i_root_quot(i_root_quot), .i_root_rem(i_root_rem),
    .o_mult_enable(o_mult_enable), .o_div_enable(o_div_enable), .o_root_enable(o_root_enable),
    .o_opX(o_opX), .o_opY(o_opY), .o_busy(o_busy), .o_done(o_done),
    .o_result(o_result), .o_remainder(o_remainder), .o_error(o_error)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({o_mult_enable, o_div_enable, o_root_enable, o_busy, o_done, o_error,
         o_result, o_remainder, o_opX, o_opY} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%b done=%b err=%b res=%0d rem=%0d opX=%0d, want all 0",
               o_busy, o_done, o_error, o_result, o_remainder, o_opX);
    end
    step();
    rst = 1'b1;
    step();
  endtask

  // k = cycles after LAUNCH that the selected unit's done arrives (0 = never).
  task automatic run_op(input string name, input logic [1:0] op, input logic [DW-1:0] x,
                        input logic [DW-1:0] y, input int k, input logic [DW-1:0] ur,
                        input logic [DW-1:0] urem, input bit noise);
    exp_t e, got;
    bit err_path, seen;
    logic [2:0] exp_en;
    err_path = (op == 2'b11) || (op == 2'b01 && y == '0);
    if (err_path) begin
      e.result = '0; e.rem = '0; e.err = 1'b1; e.lat = 1;
    end else if (k >= 1 && k <= TO) begin
      e.result = ur; e.rem = (op == 2'b00) ? '0 : urem; e.err = 1'b0; e.lat = 2 + k;
    end else begin
      e.result = '0; e.rem = '0; e.err = 1'b1; e.lat = 2 + TO;
    end
    sb.push_back(e);
    i_start = 1'b1; i_op = op; i_dataX = x; i_dataY = y;
    i_mult_product = ur; i_div_quot = ur; i_div_rem = urem;
    i_root_quot = ur; i_root_rem = urem;
    seen = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      step();
      i_start     = noise && (c == 2);
      i_mult_done = (op == 2'b00) && (c == 1 + k);
      i_div_done  = ((op == 2'b01) && (c == 1 + k)) || (noise && c == 2 && op != 2'b01);
      i_root_done = (op == 2'b10) && (c == 1 + k);
      exp_en = (!err_path && c == 1) ? {op == 2'b00, op == 2'b01, op == 2'b10} : 3'b000;
      checks++;
      if ({o_mult_enable, o_div_enable, o_root_enable} !== exp_en) begin
        failures++;
        $display("FAIL %s_enables c=%0d: got %b want %b", name, c,
                 {o_mult_enable, o_div_enable, o_root_enable}, exp_en);
      end
      checks++;
      if (o_busy !== 1'b1) begin
        failures++;
        $display("FAIL %s_busy c=%0d: got %b want 1", name, c, o_busy);
      end
      if (o_done === 1'b1) begin
        seen = 1'b1;
        got = sb.pop_front();
        checks++;
        if (c !== got.lat) begin
          failures++;
          $display("FAIL %s_latency: got %0d want %0d", name, c, got.lat);
        end
        checks++;
        if (o_result !== got.result || o_remainder !== got.rem || o_error !== got.err) begin
          failures++;
          $display("FAIL %s_result: got res=%0d rem=%0d err=%b want res=%0d rem=%0d err=%b",
                   name, o_result, o_remainder, o_error, got.result, got.rem, got.err);
        end
        checks++;
        if (o_opX !== x || o_opY !== y) begin
          failures++;
          $display("FAIL %s_operands: got X=%0d Y=%0d want X=%0d Y=%0d", name, o_opX, o_opY, x, y);
        end
      end
    end
    i_start = 1'b0; i_mult_done = 1'b0; i_div_done = 1'b0; i_root_done = 1'b0;
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s_timeout: got no o_done within 40 cycles, want o_done", name);
      void'(sb.pop_front());
    end
    step();
    checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0 || o_result !== e.result ||
        o_remainder !== e.rem || o_error !== e.err) begin
      failures++;
      $display("FAIL %s_hold: got done=%b busy=%b res=%0d rem=%0d err=%b want 0 0 %0d %0d %b",
               name, o_done, o_busy, o_result, o_remainder, o_error, e.result, e.rem, e.err);
    end
  endtask

  task automatic test_multiply();     run_op("mult", 2'b00, 16'd7, 16'd6, 3, 16'd42, 16'd9, 1'b1); endtask
  task automatic test_divide();       run_op("div", 2'b01, 16'd100, 16'd7, 2, 16'd14, 16'd2, 1'b0); endtask
  task automatic test_div_zero();     run_op("divzero", 2'b01, 16'd5, 16'd0, 1, 16'd3, 16'd3, 1'b0); endtask
  task automatic test_illegal();      run_op("illegal", 2'b11, 16'd9, 16'd9, 1, 16'd3, 16'd3, 1'b0); endtask
  task automatic test_root_timeout(); run_op("root_to", 2'b10, 16'd50, 16'd0, 0, 16'd7, 16'd1, 1'b0); endtask
  task automatic test_root_expiry();  run_op("root_exp", 2'b10, 16'd50, 16'd0, TO, 16'd7, 16'd1, 1'b0); endtask
  task automatic test_root_late();    run_op("root_late", 2'b10, 16'd50, 16'd0, TO + 1, 16'd7, 16'd1, 1'b0); endtask

  // Start held high through DONE is accepted in the very next IDLE cycle.
  task automatic test_back_to_back();
    exp_t e, got;
    logic [2:0] pattern;
    e.result = '0; e.rem = '0; e.err = 1'b1; e.lat = 1;
    sb.push_back(e);
    sb.push_back(e);
    i_start = 1'b1; i_op = 2'b11; i_dataX = 16'd1; i_dataY = 16'd2;
    pattern = '0;
    for (int c = 1; c <= 3; c++) begin
      step();
      pattern[c-1] = o_done;
      if (o_done === 1'b1) begin
        got = sb.pop_front();
        checks++;
        if (o_error !== got.err || o_result !== got.result) begin
          failures++;
          $display("FAIL b2b_result: got err=%b res=%0d want err=%b res=%0d",
                   o_error, o_result, got.err, got.result);
        end
      end
    end
    i_start = 1'b0;
    checks++;
    if (pattern !== 3'b101) begin
      failures++;
      $display("FAIL b2b_done_pattern: got %b want 101", pattern);
    end
    step();
  endtask

  task automatic test_wait_reset();
    logic saw_done;
    i_start = 1'b1; i_op = 2'b00; i_dataX = 16'd3; i_dataY = 16'd4;
    step();
    i_start = 1'b0;
    step();
    step();
    #3 rst = 1'b0;
    #1;
    checks++;
    if ({o_mult_enable, o_div_enable, o_root_enable, o_busy, o_done, o_error,
         o_result, o_remainder, o_opX, o_opY} !== '0) begin
      failures++;
      $display("FAIL wait_reset_async: got busy=%b opX=%0d opY=%0d want all 0", o_busy, o_opX, o_opY);
    end
    step();
    rst = 1'b1;
    i_mult_done = 1'b1; i_mult_product = 16'd99;
    step();
    i_mult_done = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (o_done !== 1'b0 || o_busy !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      failures++;
      $display("FAIL wait_reset_no_done: got done/busy activity after release, want none");
    end
  endtask

  initial begin
    test_reset();
    test_multiply();
    test_divide();
    test_div_zero();
    test_illegal();
    test_root_timeout();
    test_root_expiry();
    test_root_late();
    test_back_to_back();
    test_wait_reset();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_empty: got %0d entries want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
